// File: rtl/sa1x2_feed_ctrl.sv
// Job sequencer for the 1x2 systolic MAC array: clears the accumulators, feeds skewed
// operands with zero bubbles on stalls, drains the array and returns both dot products.
module sa1x2_feed_ctrl #(
  parameter int DW = 16,
  parameter int CW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          abort,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a0,
  input  logic [DW-1:0] in_a1,
  input  logic [DW-1:0] in_b,
  output logic          arr_clr,
  output logic [DW-1:0] arr_a0,
  output logic [DW-1:0] arr_a1,
  output logic [DW-1:0] arr_b0,
  input  logic [CW-1:0] arr_c0,
  input  logic [CW-1:0] arr_c1,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_c0,
  output logic [CW-1:0] res_c1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [LW-1:0] beat_cnt;
  logic [1:0]    drain_cnt;
  logic [DW-1:0] a1_skew_p0;
  logic          beat_acc;
  logic          last_beat;

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_FEED);
  assign arr_clr   = (state == S_CLEAR);
  // abort outranks a beat offered in the same cycle
  assign beat_acc  = in_ready & in_valid & ~abort;
  assign last_beat = beat_acc & (beat_cnt == LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = (beat_cnt == '0) ? S_DRAIN : S_FEED;
      S_FEED:  if (last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'd0) state_nx = S_DONE;
      S_DONE:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // drain_cnt spans the two-stage array latency plus the capture edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        beat_cnt <= len;
      end else if (abort) begin
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt - LW'(1);
      end

      if (abort) begin
        drain_cnt <= '0;
      end else if ((state != S_DRAIN) && (state_nx == S_DRAIN)) begin
        drain_cnt <= 2'd2;
      end else if ((state == S_DRAIN) && (drain_cnt != 2'd0)) begin
        drain_cnt <= drain_cnt - 2'd1;
      end
    end
  end

  // stage p0: operand registers; a1 passes one extra stage to meet the delayed b in PE1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_a0     <= '0;
      arr_b0     <= '0;
      a1_skew_p0 <= '0;
      arr_a1     <= '0;
    end else begin
      arr_a0     <= beat_acc ? in_a0 : '0;
      arr_b0     <= beat_acc ? in_b  : '0;
      a1_skew_p0 <= beat_acc ? in_a1 : '0;
      arr_a1     <= (abort || (state == S_IDLE) || (state == S_CLEAR)) ? '0 : a1_skew_p0;
    end
  end

  // result capture: sample the accumulators once PE1 has absorbed the final beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_c0    <= '0;
      res_c1    <= '0;
    end else begin
      res_valid <= (state_nx == S_DONE);
      if ((state == S_DRAIN) && (state_nx == S_DONE)) begin
        res_c0 <= arr_c0;
        res_c1 <= arr_c1;
      end
    end
  end

endmodule

// File: tb/tb_sa1x2_feed_ctrl.sv
// Randomised bench for sa1x2_feed_ctrl with a behavioural 1x2 array and a beat-level
// reference model for the feed sequence and the dot-product results.
module tb_sa1x2_feed_ctrl;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a0 = '0;
  logic [DW-1:0] in_a1 = '0;
  logic [DW-1:0] in_b = '0;
  logic          res_ready = 1'b0;
  logic          busy, in_ready, arr_clr, res_valid;
  logic [DW-1:0] arr_a0, arr_a1, arr_b0;
  logic [CW-1:0] arr_c0, arr_c1, res_c0, res_c1;

  always #5 clk = ~clk;

  sa1x2_feed_ctrl #(.DW(DW), .CW(CW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a0(in_a0), .in_a1(in_a1), .in_b(in_b),
    .arr_clr(arr_clr), .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0),
    .arr_c0(arr_c0), .arr_c1(arr_c1), .res_valid(res_valid), .res_ready(res_ready),
    .res_c0(res_c0), .res_c1(res_c1)
  );

  // behavioural array: PE0 sees b0 directly, PE1 sees b0 one cycle late
  logic [DW-1:0] b1d;
  always @(posedge clk or posedge rst) begin
    if (rst || arr_clr) begin
      arr_c0 <= '0;
      arr_c1 <= '0;
      b1d    <= '0;
    end else begin
      arr_c0 <= arr_c0 + 32'(arr_a0) * 32'(arr_b0);
      b1d    <= arr_b0;
      arr_c1 <= arr_c1 + 32'(arr_a1) * 32'(b1d);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected feed: an accepted beat lands on a0/b0 next cycle and on a1 the cycle after
  logic [DW-1:0] m_a0 = '0, m_a1 = '0, m_b0 = '0, m_skew = '0;
  logic          m_acc;
  always @(posedge rst) begin
    m_a0 = '0; m_a1 = '0; m_b0 = '0; m_skew = '0;
  end
  always @(posedge clk) begin
    if (!rst) begin
      m_acc  = in_valid && in_ready && !abort;
      m_a0   = m_acc ? in_a0 : '0;
      m_b0   = m_acc ? in_b  : '0;
      m_a1   = abort ? '0 : m_skew;
      m_skew = m_acc ? in_a1 : '0;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("feed_a0", 32'(arr_a0), 32'(m_a0));
      chk("feed_b0", 32'(arr_b0), 32'(m_b0));
      chk("feed_a1_lag", 32'(arr_a1), 32'(m_a1));
    end
  end

  logic [DW-1:0] ja0[256], ja1[256], jb[256];
  int            gap[256];

  task automatic ref_sums(input int n, output logic [31:0] e0, output logic [31:0] e1);
    e0 = '0;
    e1 = '0;
    for (int i = 0; i < n; i++) begin
      e0 = e0 + 32'(ja0[i]) * 32'(jb[i]);
      e1 = e1 + 32'(ja1[i]) * 32'(jb[i]);
    end
  endtask

  task automatic fill_random(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      ja0[i] = 16'($urandom);
      ja1[i] = 16'($urandom);
      jb[i]  = 16'($urandom);
      gap[i] = $urandom_range(0, maxgap);
    end
  endtask

  task automatic feed_beats(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    chk("clr_on", 32'(arr_clr), 1);
    chk("busy_clear", 32'(busy), 1);
    chk("rdy_clear", 32'(in_ready), 0);
    @(negedge clk);
    chk("clr_off", 32'(arr_clr), 0);
    chk("rdy_feed", 32'(in_ready), (n != 0) ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        in_valid = 1'b0;
        in_a0 = 16'($urandom);
        in_a1 = 16'($urandom);
        in_b  = 16'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_a0 = ja0[i];
      in_a1 = ja1[i];
      in_b  = jb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a0 = '0;
    in_a1 = '0;
    in_b  = '0;
  endtask

  task automatic finish_job(input int n, input int bp);
    logic [31:0] e0, e1;
    ref_sums(n, e0, e1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("res_vld_latency", 32'(res_valid), 32'(k == 3));
      chk("rdy_drain", 32'(in_ready), 0);
    end
    chk("res_c0", res_c0, e0);
    chk("res_c1", res_c1, e1);
    for (int j = 0; j < bp; j++) begin
      start = (j == 1);
      @(negedge clk);
      chk("hold_vld", 32'(res_valid), 1);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_c0", res_c0, e0);
      chk("hold_c1", res_c1, e1);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    res_ready = 1'b0;
    chk("hs_vld", 32'(res_valid), 0);
    chk("hs_busy", 32'(busy), 0);
  endtask

  task automatic run_job(input int n, input int bp);
    feed_beats(n);
    finish_job(n, bp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_clr", 32'(arr_clr), 0);
    chk("rst_vld", 32'(res_valid), 0);
    chk("rst_a0", 32'(arr_a0), 0);
    chk("rst_a1", 32'(arr_a1), 0);
    chk("rst_b0", 32'(arr_b0), 0);
    chk("rst_c0", res_c0, 0);
    chk("rst_c1", res_c1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // basic job, then identical data with bubbles
    for (int i = 0; i < 3; i++) begin
      ja0[i] = DW'(3 * i + 1);
      ja1[i] = DW'(3 * i + 2);
      jb[i]  = DW'(3 * i + 3);
      gap[i] = 0;
    end
    run_job(3, 0);
    chk("basic_c0_const", res_c0, 90);
    chk("basic_c1_const", res_c1, 108);
    gap[1] = 2;
    gap[2] = 1;
    run_job(3, 0);
    chk("stall_c0_const", res_c0, 90);

    // backpressure with an ignored start in DONE, then a clear-proving job
    gap[1] = 0;
    gap[2] = 0;
    run_job(3, 5);
    ja0[0] = 16'hFFFF;
    ja1[0] = 16'hFFFF;
    jb[0]  = 16'hFFFF;
    gap[0] = 0;
    run_job(1, 0);
    chk("ffff_c0_const", res_c0, 32'hFFFE0001);
    chk("ffff_c1_const", res_c1, 32'hFFFE0001);

    run_job(0, 1);

    // abort after two of four beats; the third beat collides with abort
    fill_random(4, 0);
    @(negedge clk);
    start = 1'b1;
    len   = LW'(4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a0 = ja0[i];
      in_a1 = ja1[i];
      in_b  = jb[i];
      abort = (i == 2);
      @(negedge clk);
    end
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdy", 32'(in_ready), 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_novld", 32'(res_valid), 0);
    end
    ja0[0] = 16'd2;
    ja1[0] = 16'd3;
    jb[0]  = 16'd4;
    gap[0] = 0;
    run_job(1, 0);
    chk("post_abort_c0", res_c0, 8);
    chk("post_abort_c1", res_c1, 12);

    // asynchronous reset in the middle of DRAIN
    fill_random(3, 1);
    feed_beats(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(in_ready), 0);
    chk("arst_clr", 32'(arr_clr), 0);
    chk("arst_vld", 32'(res_valid), 0);
    chk("arst_a0", 32'(arr_a0), 0);
    chk("arst_a1", 32'(arr_a1), 0);
    chk("arst_b0", 32'(arr_b0), 0);
    chk("arst_c0", res_c0, 0);
    chk("arst_c1", res_c1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("arst_novld", 32'(res_valid), 0);
    end
    fill_random(2, 1);
    run_job(2, 1);

    // randomised jobs, including the maximum length
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      fill_random(n, 2);
      run_job(n, $urandom_range(0, 3));
    end
    fill_random(255, 1);
    run_job(255, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
